// File: rtl/rf_pkg.sv
// Shared register-file types and defaults.
// Used by decode, WB and the scoreboarded register file.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_CNT_W  = 2;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/rf_sb_counter.sv
// Per-register outstanding-producer counter.
// Clear wins; inc and dec together cancel; both ends saturate.
module rf_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    // Net up/down step of the in-flight count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && count != CMAX) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write bypass and
// a per-register outstanding-write scoreboard.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata,
    output logic [NUM_RD-1:0]        o_rbusy,
    input  logic                     i_wen,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_alloc_en,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    output logic                     o_alloc_ready,
    input  logic                     i_flush
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [1:NREG-1];
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:1] busy;

    logic wr_nz;
    logic alloc_nz;
    logic alloc_acc;

    assign wr_nz     = i_wen && (i_waddr != ZADDR);
    assign alloc_nz  = (i_alloc_addr != ZADDR);
    assign alloc_acc = i_alloc_en && o_alloc_ready
                     && alloc_nz && !i_flush;

    // Committed writes; x0 has no storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_nz) begin
            for (int i = 1; i < NREG; i++) begin
                if (i_waddr == ADDR_W'(i)) begin
                    mem_q[i] <= i_wdata;
                end
            end
        end
    end

    assign cnt[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_sb
        logic inc;
        logic dec;

        assign inc = alloc_acc
                   && (i_alloc_addr == ADDR_W'(i));
        assign dec = wr_nz && busy[i]
                   && (i_waddr == ADDR_W'(i));

        rf_sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc),
            .dec   (dec),
            .clr   (i_flush),
            .count (cnt[i]),
            .busy  (busy[i])
        );
    end

    assign o_alloc_ready = !alloc_nz
                         || (cnt[i_alloc_addr] != CMAX);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;
        logic [DATA_W-1:0] sd;
        logic [CNT_W-1:0]  c;

        assign ra  = i_raddr[k*ADDR_W +: ADDR_W];
        assign byp = wr_nz && (i_waddr == ra);
        assign c   = cnt[ra];

        // Stored value lookup; x0 reads zero
        always_comb begin
            sd = '0;
            for (int j = 1; j < NREG; j++) begin
                if (ra == ADDR_W'(j)) begin
                    sd = mem_q[j];
                end
            end
        end

        assign o_rdata[k*DATA_W +: DATA_W] =
            byp ? i_wdata : sd;
        assign o_rbusy[k] = (c != '0)
            && !(byp && c == CNT_W'(1));
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with configurable read-port count, same-cycle write bypass, and a per-register outstanding-write scoreboard with flush for speculative execution. Sits in the ID stage of the RV32I pipeline. Decode reads operands and allocates destination producers; WB writes results and retires producers; the branch unit flushes the scoreboard on a mispredict. Writes are posedge-clocked; write-through bypass gives same-cycle read-after-write visibility.

## Interface
- `ADDR_W`, 5, register address width; `2**ADDR_W` entries.
- `DATA_W`, 32, data width.
- `NUM_RD`, 2, number of read ports (1..4).
- `CNT_W`, 2, outstanding-producer counter width per register; max in-flight `2**CNT_W-1`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_raddr`  in  NUM_RD*ADDR_W  packed read addresses; port k at `[k*ADDR_W +: ADDR_W]`.
- `o_rdata`  out  NUM_RD*DATA_W  packed read data, combinational.
- `o_rbusy`  out  NUM_RD  per-port: the register has an outstanding producer, combinational.
- `i_wen`  in  1  write enable (WB commit).
- `i_waddr`  in  ADDR_W  write address.
- `i_wdata`  in  DATA_W  write data.
- `i_alloc_en`  in  1  decode allocates a producer for `i_alloc_addr`.
- `i_alloc_addr`  in  ADDR_W  destination being allocated.
- `o_alloc_ready`  out  1  allocation will be accepted this cycle, combinational.
- `i_flush`  in  1  mispredict: clear all outstanding counts.

## Operation
- Storage: `2**ADDR_W` x `DATA_W`. Entry 0 is hardwired to 0. Writes to address 0 are dropped. Address 0 never becomes busy, and allocations to it are accepted but have no effect.
- Write: if `i_wen` and `i_waddr != 0`, the entry takes `i_wdata` at the rising edge. Writes are honoured during `i_flush`, because committed data is non-speculative.
- Read port k:
  - `o_rdata[k]` = `i_wdata` if `i_wen && i_waddr == raddr_k && raddr_k != 0`.
  - Otherwise it is the stored value.
- Scoreboard: one `CNT_W`-bit counter `cnt[r]` per register.
  - alloc_acc = `i_alloc_en && o_alloc_ready && i_alloc_addr != 0 && !i_flush`.
  - ret = `i_wen && i_waddr != 0 && cnt[i_waddr] != 0`.
  - Same address with alloc_acc and ret both true: net unchanged.
  - alloc_acc only: +1. ret only: -1.
  - Write to a register with `cnt == 0`: no underflow, counter stays 0.
- `i_flush`: all counters go to 0 at the next edge, overriding alloc and retire.
- `o_alloc_ready` = `cnt[i_alloc_addr] != 2**CNT_W-1`, or `i_alloc_addr == 0`. Decode must stall while it is low. `i_alloc_en` with ready low is ignored.
- `o_rbusy[k]` = `cnt[raddr_k] != 0` and not (the port is bypassing this cycle and `cnt[raddr_k] == 1`). The retiring last producer unblocks the reader in the same cycle.
- Same-cycle allocation does not affect `o_rbusy` until the next cycle.

## Timing
- Reset (async assert, release on clk domain): all entries 0, all counters 0.
  - Consequently `o_rdata` = 0, `o_rbusy` = 0, `o_alloc_ready` = 1.
- Read latency 0 (combinational from address and the write port). Write latency 1 edge, hidden by the bypass.
- Scoreboard update latency 1 edge. `o_alloc_ready` reflects registered counts only.
- Reset asserted mid-operation clears storage and counters immediately, regardless of clock.
- Priority per register per edge: reset > flush > (alloc/retire net) for counters. Write data is independent of flush.

## Structure
- Shared package `rf_pkg`:
  - default `ADDR_W`/`DATA_W`/`CNT_W` constants;
  - `RF_ZERO_ADDR` constant;
  - `rf_addr_t`/`rf_data_t` typedefs used by decode and WB.
- Sub-module `rf_sb_counter`: one saturating up/down counter per register. Inputs are inc, dec, clr; outputs are count and busy. It is instantiated `2**ADDR_W - 1` times via generate.
- Top-level: storage array, bypass muxes per read port, alloc-ready mux.

## Test plan
- Reset then read all 32 addresses on both ports -> every `o_rdata` = 0, `o_rbusy` = 0, `o_alloc_ready` = 1. Write x0=0xFFFFFFFF -> x0 still reads 0.
- Write x5=0xDEADBEEF while port0 reads x5 in the same cycle -> `o_rdata[0]` = 0xDEADBEEF that cycle, and x5 stays 0xDEADBEEF after the edge.
- Allocate x7 three times (CNT_W=2) -> `o_alloc_ready` = 0 for x7. A 4th alloc is ignored. Three writes to x7 -> the counter returns to 0, and `o_rbusy` drops in the cycle of the third write via bypass.
- Same cycle: alloc x9 and write x9 with cnt[x9]=1 -> cnt stays 1 and x9 stays busy next cycle. Then write x9 with cnt=0 -> no underflow, cnt stays 0.
- Allocate x1, x2, x3, then assert `i_flush` together with a write x4=0x1234 and alloc x6 -> all counts 0 next cycle, x6 not busy, x4 reads 0x1234.
- Deassert `rst_n` mid-sequence with x10 busy and holding 0x55 -> immediately x10 reads 0 and is not busy, before any clock edge.
